// File: rtl/pipe_stage_skid.sv
// Elastic pipeline-stage register with a 2-entry skid buffer, flush-to-bubble
// and a saturating stall counter. Full throughput, one cycle of latency.
module pipe_stage_skid #(
   parameter int unsigned CTRL_W   = 4,
   parameter int unsigned DATA_W   = 68,
   parameter int unsigned STALL_CW = 16
) (
   input  logic                CLK,
   input  logic                RESET,
   input  logic                FLUSH,
   input  logic                ValidIn,
   output logic                ReadyIn,
   input  logic [CTRL_W-1:0]   CtrlIn,
   input  logic [DATA_W-1:0]   DataIn,
   output logic                ValidOut,
   input  logic                ReadyOut,
   output logic [CTRL_W-1:0]   CtrlOut,
   output logic [DATA_W-1:0]   DataOut,
   output logic [1:0]          Occupancy,
   output logic [STALL_CW-1:0] StallCnt
);

   localparam logic [STALL_CW-1:0] STALL_MAX = {STALL_CW{1'b1}};

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      BUSY  = 2'd1,
      FULL  = 2'd2
   } state_t;

   state_t              r_state;
   logic                r_ready_in;
   logic                r_valid_out;
   logic [1:0]          r_occ;
   logic [CTRL_W-1:0]   r_head_ctrl;
   logic [DATA_W-1:0]   r_head_data;
   logic [CTRL_W-1:0]   r_skid_ctrl;
   logic [DATA_W-1:0]   r_skid_data;
   logic [STALL_CW-1:0] r_stall_cnt;

   state_t              w_state_nxt;
   logic                w_accept;
   logic                w_drain;
   logic [CTRL_W-1:0]   w_head_ctrl_nxt;
   logic [DATA_W-1:0]   w_head_data_nxt;
   logic [CTRL_W-1:0]   w_skid_ctrl_nxt;
   logic [DATA_W-1:0]   w_skid_data_nxt;
   logic [STALL_CW-1:0] w_stall_nxt;

   // Next-state and datapath selection; head ctrl is zeroed whenever the stage empties
   always_comb begin
      w_state_nxt     = r_state;
      w_head_ctrl_nxt = r_head_ctrl;
      w_head_data_nxt = r_head_data;
      w_skid_ctrl_nxt = r_skid_ctrl;
      w_skid_data_nxt = r_skid_data;
      w_stall_nxt     = r_stall_cnt;
      w_accept        = ValidIn & r_ready_in;
      w_drain         = r_valid_out & ReadyOut;

      if (r_valid_out && !ReadyOut && (r_stall_cnt != STALL_MAX)) begin
         w_stall_nxt = r_stall_cnt + STALL_CW'(1);
      end

      if (FLUSH) begin
         w_state_nxt     = EMPTY;
         w_head_ctrl_nxt = '0;
      end else begin
         case (r_state)
            EMPTY: begin
               if (w_accept) begin
                  w_state_nxt     = BUSY;
                  w_head_ctrl_nxt = CtrlIn;
                  w_head_data_nxt = DataIn;
               end
            end
            BUSY: begin
               if (w_accept && w_drain) begin
                  w_head_ctrl_nxt = CtrlIn;
                  w_head_data_nxt = DataIn;
               end else if (w_accept) begin
                  w_state_nxt     = FULL;
                  w_skid_ctrl_nxt = CtrlIn;
                  w_skid_data_nxt = DataIn;
               end else if (w_drain) begin
                  w_state_nxt     = EMPTY;
                  w_head_ctrl_nxt = '0;
               end
            end
            FULL: begin
               if (w_drain) begin
                  w_state_nxt     = BUSY;
                  w_head_ctrl_nxt = r_skid_ctrl;
                  w_head_data_nxt = r_skid_data;
               end
            end
            default: begin
               w_state_nxt     = EMPTY;
               w_head_ctrl_nxt = '0;
            end
         endcase
      end
   end

   // State and output registers; flags are decoded from the next state
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state     <= EMPTY;
         r_ready_in  <= 1'b1;
         r_valid_out <= 1'b0;
         r_occ       <= 2'd0;
         r_head_ctrl <= '0;
         r_head_data <= '0;
         r_skid_ctrl <= '0;
         r_skid_data <= '0;
         r_stall_cnt <= '0;
      end else begin
         r_state     <= w_state_nxt;
         r_ready_in  <= (w_state_nxt != FULL);
         r_valid_out <= (w_state_nxt != EMPTY);
         r_occ       <= w_state_nxt;
         r_head_ctrl <= w_head_ctrl_nxt;
         r_head_data <= w_head_data_nxt;
         r_skid_ctrl <= w_skid_ctrl_nxt;
         r_skid_data <= w_skid_data_nxt;
         r_stall_cnt <= w_stall_nxt;
      end
   end

   assign ReadyIn   = r_ready_in;
   assign ValidOut  = r_valid_out;
   assign CtrlOut   = r_head_ctrl;
   assign DataOut   = r_head_data;
   assign Occupancy = r_occ;
   assign StallCnt  = r_stall_cnt;

endmodule
